// File: rtl/fb_swap_ctrl_if.sv
// ---------------------------------------------------------------------------
// fb_swap_ctrl_if -- pixel write bus between the pattern source, the
// double-buffer controller and the frame RAM write port.
//
//   wr_valid / wr_addr / wr_rgb : source presents a pixel
//   wr_ready                    : controller accepts the pixel this cycle
//   fill_start                  : one-cycle pulse, source restarts at address 0
//   ram_we / ram_waddr / ram_wdata : frame RAM write port, {back bit, addr}
//
// modport master : pattern source side (drives the pixel request)
// modport slave  : controller side (fb_swap_ctrl)
// ---------------------------------------------------------------------------
interface fb_swap_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 24
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_rgb;
    logic          wr_ready;
    logic          fill_start;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [DW-1:0] ram_wdata;

    modport master (
        output wr_valid, wr_addr, wr_rgb,
        input  wr_ready, fill_start, ram_we, ram_waddr, ram_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_rgb,
        output wr_ready, fill_start, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/fb_swap_ctrl.sv
// ---------------------------------------------------------------------------
// fb_swap_ctrl -- double-buffered frame RAM controller.
//
// A pattern source fills the back buffer while the panel scanner reads the
// front buffer. Once a whole frame (2^AW pixels) has been written, the next
// vsync swaps the buffers. A vsync arriving while no complete frame is
// waiting is a repeat frame: the scanner re-shows the current front buffer.
//
// Ports:
//   pixclk     : sole clock, rising edge
//   reset      : asynchronous, active-high
//   vsync      : single-cycle frame boundary pulse from the scanner
//   bus        : fb_swap_ctrl_if.slave (pixel handshake + RAM write port)
//   front_sel  : buffer currently read by the scanner
//   display    : high once a complete frame has been shown
//   frame_id   : count of completed swaps, wraps 127 -> 0
//   drop_cnt   : count of repeat frames, saturating at 255
//
// Build option: define FB_DROP_CNT_EN to build the repeat-frame counter;
// without it drop_cnt is tied to 0.
//
// Registered outputs change on the edge that leaves IDLE / SWAP, so
// fill_start, the new front_sel and frame_id all appear together in the
// first cycle of the new fill.
// ---------------------------------------------------------------------------
module fb_swap_ctrl #(
    parameter int AW = 9,
    parameter int DW = 24
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          vsync,
    fb_swap_ctrl_if.slave bus,
    output logic          front_sel,
    output logic          display,
    output logic [6:0]    frame_id,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, READY, SWAP} state_t;

    // Counter value just before the final write of a frame.
    localparam logic [AW:0] LAST = (AW+1)'((1 << AW) - 1);

    state_t        state;
    logic [AW:0]   fill_cnt;
    logic          fill_start;
    logic          accept;
    logic [DW-1:0] px_data;

    assign bus.wr_ready   = (state == FILL);
    assign accept         = bus.wr_valid && (state == FILL);
    assign px_data        = bus.wr_rgb;

    // Writes always land in the back buffer, never the one being scanned.
    assign bus.ram_we     = accept;
    assign bus.ram_waddr  = {~front_sel, bus.wr_addr};
    assign bus.ram_wdata  = px_data;
    assign bus.fill_start = fill_start;

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            front_sel  <= 1'b0;
            display    <= 1'b0;
            frame_id   <= '0;
            fill_start <= 1'b0;
        end else begin
            fill_start <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= FILL;
                    fill_cnt   <= '0;
                    fill_start <= 1'b1;
                end
                FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST) state <= READY;
                    end
                end
                READY: begin
                    if (vsync) state <= SWAP;
                end
                SWAP: begin
                    state      <= FILL;
                    fill_cnt   <= '0;
                    front_sel  <= ~front_sel;
                    display    <= 1'b1;
                    frame_id   <= frame_id + 1'b1;
                    fill_start <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_DROP_CNT_EN
    // Any vsync outside READY re-shows the current frame. A vsync on the
    // final fill write is still seen in FILL, so it counts here as well.
    logic rpt_ev;
    assign rpt_ev = vsync && (state != READY);

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else if (rpt_ev && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
